// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 INCR-burst slave over a line-granular 64B SRAM model.
// Define AXI_MEM_BACKPRESSURE_EN to add LFSR-driven ready stalls and rvalid deferral.
module axi4_mem_responder #(
   parameter int ADDR_WIDTH = 64,
   parameter int MEM_DEPTH  = 4096,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            arid,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic [7:0]            arlen,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [7:0]            rid,
   output logic [511:0]          rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   input  logic [7:0]            awid,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [7:0]            awlen,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [511:0]          wdata,
   input  logic [63:0]           wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [7:0]            bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready
);

   localparam int LW = $clog2(MEM_DEPTH);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [ADDR_WIDTH-1:0] LINE_B = ADDR_WIDTH'(64);
`ifdef AXI_MEM_BACKPRESSURE_EN
   localparam logic [15:0] WAIT_END = 16'(RD_LATENCY + 1);
`else
   localparam logic [15:0] WAIT_END = 16'(RD_LATENCY);
`endif

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return a[ADDR_WIDTH-1:LW+6] == '0;
   endfunction

   function automatic logic [511:0] fill(input logic [ADDR_WIDTH-1:0] a);
      return {8{64'(a)}};
   endfunction

   logic [511:0]         mem [MEM_DEPTH];
   logic [MEM_DEPTH-1:0] written;

   // Sub-line address bits carry no meaning for a 64B-beat port.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{araddr[5:0], awaddr[5:0]};

   logic stall;
`ifdef AXI_MEM_BACKPRESSURE_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
   end
   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   r_state_t              r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_fetch;
   logic [7:0]            r_len;
   logic [7:0]            r_beat;
   logic [15:0]           r_cnt;
   logic                  ar_rdy;
   logic [LW-1:0]         r_idx;
   logic [511:0]          r_data_nx;
   logic [1:0]            r_resp_nx;

   assign arready = ar_rdy & ~stall;

   // In R_DATA the next beat is fetched while the current one is on the bus.
   always_comb begin
      r_fetch   = (r_state == R_DATA) ? r_addr + LINE_B : r_addr;
      r_idx     = r_fetch[LW+5:6];
      r_data_nx = '0;
      r_resp_nx = SLVERR;
      if (in_range(r_fetch)) begin
         r_resp_nx = OKAY;
         r_data_nx = written[r_idx] ? mem[r_idx] : fill(r_fetch);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= R_IDLE;
         ar_rdy  <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_cnt   <= '0;
         rid     <= '0;
         rdata   <= '0;
         rresp   <= OKAY;
         rlast   <= 1'b0;
         rvalid  <= 1'b0;
      end else begin
         unique case (r_state)
            R_IDLE: begin
               ar_rdy <= 1'b1;
               if (arvalid && arready) begin
                  ar_rdy  <= 1'b0;
                  rid     <= arid;
                  r_addr  <= {araddr[ADDR_WIDTH-1:6], 6'b0};
                  r_len   <= arlen;
                  r_beat  <= '0;
                  r_cnt   <= '0;
                  r_state <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (r_cnt == WAIT_END) begin
                  rvalid  <= 1'b1;
                  rdata   <= r_data_nx;
                  rresp   <= r_resp_nx;
                  rlast   <= (r_len == 8'd0);
                  r_state <= R_DATA;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  if (rlast) begin
                     rvalid  <= 1'b0;
                     rlast   <= 1'b0;
                     ar_rdy  <= 1'b1;
                     r_state <= R_IDLE;
                  end else begin
                     r_addr <= r_fetch;
                     r_beat <= r_beat + 8'd1;
                     rdata  <= r_data_nx;
                     rresp  <= r_resp_nx;
                     rlast  <= (r_beat + 8'd1 == r_len);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   w_state_t              w_state;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_len;
   logic [7:0]            w_beat;
   logic                  w_over;
   logic                  w_err;
   logic                  aw_rdy;
   logic                  w_rdy;
   logic                  w_ok;
   logic                  w_fire;
   logic                  w_commit;
   logic [LW-1:0]         w_idx;
   logic [511:0]          w_base;
   logic [511:0]          w_merged;

   assign awready = aw_rdy & ~stall;
   assign wready  = w_rdy & ~stall;

   always_comb begin
      w_idx    = w_addr[LW+5:6];
      w_ok     = in_range(w_addr);
      w_fire   = (w_state == W_DATA) && wvalid && wready;
      w_commit = w_fire && w_ok && !w_over;
      w_base   = written[w_idx] ? mem[w_idx] : fill(w_addr);
      w_merged = w_base;
      for (int i = 0; i < 64; i++) begin
         if (wstrb[i]) w_merged[i*8 +: 8] = wdata[i*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (w_commit) mem[w_idx] <= w_merged;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state <= W_IDLE;
         aw_rdy  <= 1'b0;
         w_rdy   <= 1'b0;
         w_addr  <= '0;
         w_len   <= '0;
         w_beat  <= '0;
         w_over  <= 1'b0;
         w_err   <= 1'b0;
         bid     <= '0;
         bresp   <= OKAY;
         bvalid  <= 1'b0;
         written <= '0;
      end else begin
         if (w_commit) written[w_idx] <= 1'b1;
         unique case (w_state)
            W_IDLE: begin
               aw_rdy <= 1'b1;
               if (awvalid && awready) begin
                  aw_rdy  <= 1'b0;
                  w_rdy   <= 1'b1;
                  bid     <= awid;
                  w_addr  <= {awaddr[ADDR_WIDTH-1:6], 6'b0};
                  w_len   <= awlen;
                  w_beat  <= '0;
                  w_over  <= 1'b0;
                  w_err   <= 1'b0;
                  w_state <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  if (wlast) begin
                     w_rdy   <= 1'b0;
                     bvalid  <= 1'b1;
                     bresp   <= (w_err || !w_ok || w_over ||
                                 (w_beat != w_len)) ? SLVERR : OKAY;
                     w_state <= W_RESP;
                  end else begin
                     if (!w_ok) w_err <= 1'b1;
                     // Beats past awlen are swallowed until wlast arrives.
                     if (w_beat == w_len) begin
                        w_over <= 1'b1;
                     end else begin
                        w_beat <= w_beat + 8'd1;
                        w_addr <= w_addr + LINE_B;
                     end
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  bresp   <= OKAY;
                  aw_rdy  <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

endmodule
